// File: rtl/ffstdp_sweep_ctrl.sv
// ffstdp_sweep_ctrl: walks every {pre, post} synapse once per training sample.
// For each pre row it fetches the pre spike count, then for each post column
// it reads the synapse weight, hands it to the external update stage and
// writes the new weight back to the same address in the following cycle.
// Optional build macro FFSTDP_SKIP_ZERO_PRE_EN: rows whose pre count has
// zero low five bits are skipped without touching the synapse SRAM.
module ffstdp_sweep_ctrl #(
    parameter int unsigned PRE_ADDR_WIDTH  = 8,
    parameter int unsigned POST_ADDR_WIDTH = 7,
    parameter int unsigned PRE_CNT_WIDTH   = 8,
    parameter int unsigned POST_CNT_WIDTH  = 7,
    parameter int unsigned WEIGHT_WIDTH    = 8
) (
    input  logic                                      CLK,
    input  logic                                      RST_N,
    input  logic                                      START,
    input  logic                                      IS_POS,
    input  logic                                      IS_TRAIN,
    output logic                                      BUSY,
    output logic                                      DONE,
    output logic [PRE_ADDR_WIDTH-1:0]                 PRE_CNT_ADDR,
    input  logic [PRE_CNT_WIDTH-1:0]                  PRE_CNT_RDATA,
    output logic [POST_ADDR_WIDTH-1:0]                POST_CNT_ADDR,
    input  logic [POST_CNT_WIDTH-1:0]                 POST_CNT_RDATA,
    output logic                                      SYN_CS,
    output logic                                      SYN_WE,
    output logic [PRE_ADDR_WIDTH+POST_ADDR_WIDTH-1:0] SYN_ADDR,
    output logic [WEIGHT_WIDTH-1:0]                   SYN_WDATA,
    input  logic [WEIGHT_WIDTH-1:0]                   SYN_RDATA,
    output logic                                      UPD_TREF_EVENT,
    output logic                                      UPD_IS_POS,
    output logic [PRE_CNT_WIDTH-1:0]                  UPD_PRE_CNT,
    output logic [POST_CNT_WIDTH-1:0]                 UPD_POST_CNT,
    output logic [WEIGHT_WIDTH-1:0]                   UPD_WSYN_CURR,
    input  logic [WEIGHT_WIDTH-1:0]                   UPD_WSYN_NEW
);

`ifdef FFSTDP_SKIP_ZERO_PRE_EN
    // Number of pre-count bits that must be zero for a row to be skipped.
    localparam int unsigned SKIP_W = (PRE_CNT_WIDTH < 5) ? PRE_CNT_WIDTH : 5;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE_RD  = 3'd1,
        ST_PRE_LAT = 3'd2,
        ST_SYN_RD  = 3'd3,
        ST_SYN_WR  = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [PRE_ADDR_WIDTH-1:0]  pre_idx_q, pre_idx_d;
    logic [POST_ADDR_WIDTH-1:0] post_idx_q, post_idx_d;
    logic [PRE_CNT_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
    logic                       is_pos_q, is_pos_d;
    logic                       pre_last;
    logic                       post_last;

    assign pre_last  = (pre_idx_q == {PRE_ADDR_WIDTH{1'b1}});
    assign post_last = (post_idx_q == {POST_ADDR_WIDTH{1'b1}});

    // State register; reset drops any sweep in progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep indices, latched pre count and latched polarity.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_idx_q  <= '0;
            post_idx_q <= '0;
            pre_cnt_q  <= '0;
            is_pos_q   <= 1'b0;
        end else begin
            pre_idx_q  <= pre_idx_d;
            post_idx_q <= post_idx_d;
            pre_cnt_q  <= pre_cnt_d;
            is_pos_q   <= is_pos_d;
        end
    end

    // Next-state and index sequencing.
    always_comb begin
        state_d    = state_q;
        pre_idx_d  = pre_idx_q;
        post_idx_d = post_idx_q;
        pre_cnt_d  = pre_cnt_q;
        is_pos_d   = is_pos_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (IS_TRAIN) begin
                        is_pos_d   = IS_POS;
                        pre_idx_d  = '0;
                        post_idx_d = '0;
                        state_d    = ST_PRE_RD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_PRE_RD: begin
                state_d = ST_PRE_LAT;
            end
            ST_PRE_LAT: begin
                pre_cnt_d = PRE_CNT_RDATA;
                state_d   = ST_SYN_RD;
`ifdef FFSTDP_SKIP_ZERO_PRE_EN
                if (PRE_CNT_RDATA[SKIP_W-1:0] == '0) begin
                    if (pre_last) begin
                        state_d = ST_FIN;
                    end else begin
                        pre_idx_d  = pre_idx_q + PRE_ADDR_WIDTH'(1);
                        post_idx_d = '0;
                        state_d    = ST_PRE_RD;
                    end
                end
`endif
            end
            ST_SYN_RD: begin
                state_d = ST_SYN_WR;
            end
            ST_SYN_WR: begin
                if (!post_last) begin
                    post_idx_d = post_idx_q + POST_ADDR_WIDTH'(1);
                    state_d    = ST_SYN_RD;
                end else if (!pre_last) begin
                    post_idx_d = '0;
                    pre_idx_d  = pre_idx_q + PRE_ADDR_WIDTH'(1);
                    state_d    = ST_PRE_RD;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; everything is zero outside the state that uses it.
    always_comb begin
        BUSY           = 1'b0;
        DONE           = 1'b0;
        PRE_CNT_ADDR   = '0;
        POST_CNT_ADDR  = '0;
        SYN_CS         = 1'b0;
        SYN_WE         = 1'b0;
        SYN_ADDR       = '0;
        SYN_WDATA      = '0;
        UPD_TREF_EVENT = 1'b0;
        UPD_IS_POS     = 1'b0;
        UPD_PRE_CNT    = '0;
        UPD_POST_CNT   = '0;
        UPD_WSYN_CURR  = '0;
        unique case (state_q)
            ST_PRE_RD: begin
                BUSY         = 1'b1;
                UPD_IS_POS   = is_pos_q;
                PRE_CNT_ADDR = pre_idx_q;
            end
            ST_PRE_LAT: begin
                BUSY       = 1'b1;
                UPD_IS_POS = is_pos_q;
            end
            ST_SYN_RD: begin
                BUSY          = 1'b1;
                UPD_IS_POS    = is_pos_q;
                SYN_CS        = 1'b1;
                SYN_ADDR      = {pre_idx_q, post_idx_q};
                POST_CNT_ADDR = post_idx_q;
            end
            ST_SYN_WR: begin
                BUSY           = 1'b1;
                UPD_IS_POS     = is_pos_q;
                UPD_TREF_EVENT = 1'b1;
                UPD_WSYN_CURR  = SYN_RDATA;
                UPD_POST_CNT   = POST_CNT_RDATA;
                UPD_PRE_CNT    = pre_cnt_q;
                SYN_CS         = 1'b1;
                SYN_WE         = 1'b1;
                SYN_ADDR       = {pre_idx_q, post_idx_q};
                SYN_WDATA      = UPD_WSYN_NEW;
            end
            ST_FIN: begin
                DONE = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/ffstdp_sweep_ctrl.md
FFSTDP_SWEEP_CTRL -- requirements
Module: ffstdp_sweep_ctrl

Interface
REQ-001 SHALL have parameter PRE_ADDR_WIDTH, default 8, log2 of pre-neuron count swept.
REQ-002 SHALL have parameter POST_ADDR_WIDTH, default 7, log2 of post-neuron count swept.
REQ-003 SHALL have parameter PRE_CNT_WIDTH, default 8, pre spike counter width.
REQ-004 SHALL have parameter POST_CNT_WIDTH, default 7, post spike counter width.
REQ-005 SHALL have parameter WEIGHT_WIDTH, default 8, signed synapse weight width.
REQ-006 SHALL have port CLK  in  1  single clock, all logic rising-edge.
REQ-007 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port START  in  1  one-cycle sweep request.
REQ-009 SHALL have port IS_POS  in  1  sample polarity, sampled with START.
REQ-010 SHALL have port IS_TRAIN  in  1  training enable, sampled with START.
REQ-011 SHALL have port BUSY  out  1  high from the cycle after an accepted START until DONE.
REQ-012 SHALL have port DONE  out  1  one-cycle sweep-complete pulse.
REQ-013 SHALL have port PRE_CNT_ADDR  out  PRE_ADDR_WIDTH  pre spike counter read address.
REQ-014 SHALL have port PRE_CNT_RDATA  in  PRE_CNT_WIDTH  pre count, valid 1 cycle after address.
REQ-015 SHALL have port POST_CNT_ADDR  out  POST_ADDR_WIDTH  post spike counter read address.
REQ-016 SHALL have port POST_CNT_RDATA  in  POST_CNT_WIDTH  post count, valid 1 cycle after address.
REQ-017 SHALL have port SYN_CS  out  1  synapse SRAM chip select.
REQ-018 SHALL have port SYN_WE  out  1  synapse SRAM write enable, meaningful only with SYN_CS.
REQ-019 SHALL have port SYN_ADDR  out  PRE_ADDR_WIDTH+POST_ADDR_WIDTH  address {pre_idx, post_idx}.
REQ-020 SHALL have port SYN_WDATA  out  WEIGHT_WIDTH  write-back weight.
REQ-021 SHALL have port SYN_RDATA  in  WEIGHT_WIDTH  read weight, valid 1 cycle after read.
REQ-022 SHALL have ports UPD_TREF_EVENT/UPD_IS_POS (out, 1), UPD_PRE_CNT (out, PRE_CNT_WIDTH), UPD_POST_CNT (out, POST_CNT_WIDTH), UPD_WSYN_CURR (out, WEIGHT_WIDTH), UPD_WSYN_NEW (in, WEIGHT_WIDTH) to the downstream combinational weight-update stage.

Function
REQ-023 SHALL implement FSM IDLE, PRE_RD, PRE_LAT, SYN_RD, SYN_WR, FIN.
REQ-024 IDLE: START with IS_TRAIN=1 latches IS_POS, clears pre_idx/post_idx, goes PRE_RD; START with IS_TRAIN=0 goes FIN with no memory access; START outside IDLE ignored.
REQ-025 PRE_RD drives PRE_CNT_ADDR=pre_idx; PRE_LAT registers PRE_CNT_RDATA into pre_cnt_q, then SYN_RD.
REQ-026 SYN_RD: SYN_CS=1, SYN_WE=0, SYN_ADDR={pre_idx,post_idx}, POST_CNT_ADDR=post_idx; next state SYN_WR.
REQ-027 SYN_WR: UPD_TREF_EVENT=1, UPD_WSYN_CURR=SYN_RDATA, UPD_POST_CNT=POST_CNT_RDATA, UPD_PRE_CNT=pre_cnt_q; SYN_CS=1, SYN_WE=1, same SYN_ADDR, SYN_WDATA=UPD_WSYN_NEW, same cycle.
REQ-028 After SYN_WR: post_idx not max -> increment, SYN_RD; post_idx max and pre_idx not max -> post_idx=0, pre_idx+1, PRE_RD; both max -> FIN.
REQ-029 FIN: DONE=1 for exactly one cycle, BUSY=0, then IDLE; START in FIN ignored.
REQ-030 Sweep latency (no skip): 2^PRE_ADDR_WIDTH*(2+2*2^POST_ADDR_WIDTH)+1 cycles START to DONE; each synapse read and written exactly once.
REQ-031 UPD_IS_POS SHALL equal the latched polarity throughout the sweep; all UPD_* and SYN_* outputs 0 outside their active states.

Reset
REQ-032 RST_N low SHALL force IDLE, indices 0, pre_cnt_q 0, all outputs 0 immediately, including mid-sweep (no further SRAM write); sweep not resumed after release.

Configuration
REQ-033 Macro FFSTDP_SKIP_ZERO_PRE_EN defined: in PRE_LAT, if PRE_CNT_RDATA[4:0]==0 the whole row SHALL be skipped (no SYN access, go to next pre or FIN); undefined: every row swept per REQ-028.

Verification
REQ-034 PRE=1,POST=1 widths, START IS_TRAIN=1 -> 4 SYN_WR cycles, addresses 0,1,2,3 in order, DONE at cycle 13 after START.
REQ-035 SYN_RDATA=8'sd10, UPD_WSYN_NEW=8'sd12 -> SYN_WDATA=12 written to same address in SYN_WR cycle.
REQ-036 START with IS_TRAIN=0 -> DONE 1 cycle later, SYN_CS never asserted.
REQ-037 RST_N low during second SYN_RD -> all outputs 0 same cycle, no write, DONE never pulses.
REQ-038 With FFSTDP_SKIP_ZERO_PRE_EN, pre counts {32,5} -> row 0 skipped, only addresses 2,3 written; without macro all 4 written.
